jtoutrun_rom_arb3: RTL

Read-only arbiter that shares one SDRAM bank among three ROM requesters: char, scroll and obj gfx, or sound and PCM. Each slot has a one-entry cache holding the address, data and a valid bit. A miss raises a request to the SDRAM controller; requests are served one at a time in round-robin order. The block sits between the gfx/sound fetch logic and the SDRAM controller bank port, in place of the fixed-priority slot helpers.

---
 rtl/jtoutrun_rom_arb3_if.sv | 39 +++
 rtl/jtoutrun_rom_arb3.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtoutrun_rom_arb3_if.sv
// ---------------------------------------------------------------------------
// jtoutrun_rom_arb3_if
// Read-only SDRAM bank port shared by the three ROM slots.
//
//   addr  22  SDRAM word address      (arbiter -> controller)
//   req    1  read request            (arbiter -> controller)
//   ack    1  request accepted        (controller -> arbiter)
//   dst    1  first 16-bit word valid (controller -> arbiter)
//   rdy    1  last word delivered     (controller -> arbiter)
//   read  16  read data               (controller -> arbiter)
//
// master: the arbiter side. slave: the SDRAM controller side.
// ---------------------------------------------------------------------------
interface jtoutrun_rom_arb3_if;
  logic [21:0] addr;
  logic        req;
  logic        ack;
  logic        dst;
  logic        rdy;
  logic [15:0] read;

  modport master (
    output addr,
    output req,
    input  ack,
    input  dst,
    input  rdy,
    input  read
  );

  modport slave (
    input  addr,
    input  req,
    output ack,
    output dst,
    output rdy,
    output read
  );
endinterface

// File: rtl/jtoutrun_rom_arb3.sv
// ---------------------------------------------------------------------------
// jtoutrun_rom_arb3
// Three-slot read-only ROM arbiter in front of one SDRAM bank. Every slot
// owns a one-entry cache (address, data, valid). A slot whose request misses
// its cache becomes pending; pending slots are served one transfer at a time
// in round-robin order.
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active low
//   slotN_addr  AWN  read address (DW-wide words), N = 0..2
//   slotN_cs         slot request enable
//   slotN_clr        invalidate the slot cache on the next edge
//   slotN_ok         slotN_dout is valid for slotN_addr (combinational hit)
//   slotN_dout  DW   cached data
//   sdram            SDRAM bank port (see jtoutrun_rom_arb3_if)
//
// States
//   IDLE      | no transfer in flight; pick the next pending slot
//   WAIT_ACK  | sdram.req held high with a stable address until ack
//   WAIT_DATA | collect dst/next word into the granted slot until rdy
// ---------------------------------------------------------------------------
module jtoutrun_rom_arb3 #(
  parameter int          AW0     = 19,
  parameter int          AW1     = 19,
  parameter int          AW2     = 19,
  parameter int          DW      = 32,
  parameter logic [21:0] OFFSET0 = 22'h0,
  parameter logic [21:0] OFFSET1 = 22'h0,
  parameter logic [21:0] OFFSET2 = 22'h0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [AW0-1:0]          slot0_addr,
  input  logic                    slot0_cs,
  input  logic                    slot0_clr,
  output logic                    slot0_ok,
  output logic [DW-1:0]           slot0_dout,

  input  logic [AW1-1:0]          slot1_addr,
  input  logic                    slot1_cs,
  input  logic                    slot1_clr,
  output logic                    slot1_ok,
  output logic [DW-1:0]           slot1_dout,

  input  logic [AW2-1:0]          slot2_addr,
  input  logic                    slot2_cs,
  input  logic                    slot2_clr,
  output logic                    slot2_ok,
  output logic [DW-1:0]           slot2_dout,

  jtoutrun_rom_arb3_if.master     sdram
);

  localparam int AWM01 = (AW0 > AW1) ? AW0 : AW1;
  localparam int AWM   = (AWM01 > AW2) ? AWM01 : AW2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t          state;

  logic [AW0-1:0]  cached0;
  logic [AW1-1:0]  cached1;
  logic [AW2-1:0]  cached2;
  // Data is kept 32 bits wide regardless of DW; for DW=16 the upper half is
  // simply never written.
  logic [31:0]     data0;
  logic [31:0]     data1;
  logic [31:0]     data2;
  logic [2:0]      valid;

  logic [2:0]      hit;
  logic [2:0]      pending;
  logic            any_pend;
  logic [1:0]      ptr;
  logic [1:0]      gnt;
  logic [1:0]      next_gnt;
  logic [AWM-1:0]  req_addr;
  logic [AWM-1:0]  next_addr;
  logic [21:0]     next_sdaddr;
  logic            hi_pend;

  // ---------------------------------------------------------------------
  // Hit detection: zero latency, straight from the registered cache.
  // ---------------------------------------------------------------------
  assign hit[0] = slot0_cs & valid[0] & (slot0_addr == cached0);
  assign hit[1] = slot1_cs & valid[1] & (slot1_addr == cached1);
  assign hit[2] = slot2_cs & valid[2] & (slot2_addr == cached2);

  assign pending  = {slot2_cs, slot1_cs, slot0_cs} & ~hit;
  assign any_pend = |pending;

  assign slot0_ok   = hit[0];
  assign slot1_ok   = hit[1];
  assign slot2_ok   = hit[2];
  assign slot0_dout = data0[DW-1:0];
  assign slot1_dout = data1[DW-1:0];
  assign slot2_dout = data2[DW-1:0];

  // ---------------------------------------------------------------------
  // Round-robin pick: search starts at the slot after the last grant.
  // ---------------------------------------------------------------------
  always_comb begin
    next_gnt = 2'd0;
    case (ptr)
      2'd0:    next_gnt = pending[1] ? 2'd1 : (pending[2] ? 2'd2 : 2'd0);
      2'd1:    next_gnt = pending[2] ? 2'd2 : (pending[0] ? 2'd0 : 2'd1);
      default: next_gnt = pending[0] ? 2'd0 : (pending[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Slot addresses count DW-wide words; the SDRAM counts 16-bit words.
  function automatic logic [21:0] word_addr(input logic [21:0] a);
    return (DW == 32) ? {a[20:0], 1'b0} : a;
  endfunction

  always_comb begin
    next_addr   = '0;
    next_sdaddr = '0;
    case (next_gnt)
      2'd1: begin
        next_addr   = AWM'(slot1_addr);
        next_sdaddr = OFFSET1 + word_addr(22'(slot1_addr));
      end
      2'd2: begin
        next_addr   = AWM'(slot2_addr);
        next_sdaddr = OFFSET2 + word_addr(22'(slot2_addr));
      end
      default: begin
        next_addr   = AWM'(slot0_addr);
        next_sdaddr = OFFSET0 + word_addr(22'(slot0_addr));
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Transfer FSM and cache update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gnt        <= 2'd0;
      req_addr   <= '0;
      hi_pend    <= 1'b0;
      valid      <= 3'b000;
      cached0    <= '0;
      cached1    <= '0;
      cached2    <= '0;
      data0      <= '0;
      data1      <= '0;
      data2      <= '0;
      sdram.req  <= 1'b0;
      sdram.addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            gnt        <= next_gnt;
            ptr        <= next_gnt;
            req_addr   <= next_addr;
            sdram.addr <= next_sdaddr;
            sdram.req  <= 1'b1;
            // The data register is overwritten during the fill, so the old
            // entry must not be able to hit in the meantime.
            valid[next_gnt] <= 1'b0;
            state      <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (sdram.ack) begin
            sdram.req <= 1'b0;
            state     <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (hi_pend) begin
            hi_pend <= 1'b0;
            case (gnt)
              2'd1:    data1[31:16] <= sdram.read;
              2'd2:    data2[31:16] <= sdram.read;
              default: data0[31:16] <= sdram.read;
            endcase
          end
          if (sdram.dst) begin
            hi_pend <= (DW == 32);
            case (gnt)
              2'd1:    data1[15:0] <= sdram.read;
              2'd2:    data2[15:0] <= sdram.read;
              default: data0[15:0] <= sdram.read;
            endcase
          end
          if (sdram.rdy) begin
            hi_pend <= 1'b0;
            case (gnt)
              2'd1:    cached1 <= req_addr[AW1-1:0];
              2'd2:    cached2 <= req_addr[AW2-1:0];
              default: cached0 <= req_addr[AW0-1:0];
            endcase
            valid[gnt] <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Placed last so a clear coinciding with the fill of the same slot wins.
      if (slot0_clr) valid[0] <= 1'b0;
      if (slot1_clr) valid[1] <= 1'b0;
      if (slot2_clr) valid[2] <= 1'b0;
    end
  end

endmodule
